// File: rtl/sc_backgscroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sc_backgscroll_ctrl
// Purpose  : Background-scroll controller FSM for the road playfield. It
//            drives the background shift register (clear/load strobes) and
//            the distance counter (upcount strobe). A prescaler sets the
//            scroll rate, and a wrapping row index tracks the top row.
// Ports    : SC_BACKGSCROLL_CLOCK_50           - system clock (rising edge)
//            SC_BACKGSCROLL_RESET_InLow        - synchronous reset, active low
//            SC_BACKGSCROLL_startButton_InLow  - start/restart, active low
//            SC_BACKGSCROLL_pause_InLow        - pause level, active low
//            SC_BACKGSCROLL_speed_In           - speed select, P = BASE>>speed
//            SC_BACKGSCROLL_clear_OutLow       - clear strobe, active low
//            SC_BACKGSCROLL_load_OutLow        - shift/load strobe, active low
//            SC_BACKGSCROLL_upcount_OutLow     - distance increment, active low
//            SC_BACKGSCROLL_rowIndex_Out       - current top row
//            SC_BACKGSCROLL_running_Out        - high in RUN/SHIFT/COUNT/PAUSE
//            SC_BACKGSCROLL_wrap_OutLow        - row wrap strobe, active low
// Config   : SC_BACKGSCROLL_WRAP_IRQ_EN enables the wrap strobe; otherwise the
//            wrap output is tied inactive (1).
// Revision : 1.0 - initial release
// ============================================================================
module sc_backgscroll_ctrl #(
  parameter int BASE_PERIOD = 256,
  parameter int SPD_W       = 2,
  parameter int ROWS        = 16,
  parameter int ROW_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             SC_BACKGSCROLL_CLOCK_50,
  input  logic             SC_BACKGSCROLL_RESET_InLow,
  input  logic             SC_BACKGSCROLL_startButton_InLow,
  input  logic             SC_BACKGSCROLL_pause_InLow,
  input  logic [SPD_W-1:0] SC_BACKGSCROLL_speed_In,
  output logic             SC_BACKGSCROLL_clear_OutLow,
  output logic             SC_BACKGSCROLL_load_OutLow,
  output logic             SC_BACKGSCROLL_upcount_OutLow,
  output logic [ROW_W-1:0] SC_BACKGSCROLL_rowIndex_Out,
  output logic             SC_BACKGSCROLL_running_Out,
  output logic             SC_BACKGSCROLL_wrap_OutLow
);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_IDLE     = 3'd1,
    S_INIT     = 3'd2,
    S_WAIT_REL = 3'd3,
    S_RUN      = 3'd4,
    S_SHIFT    = 3'd5,
    S_COUNT    = 3'd6,
    S_PAUSE    = 3'd7
  } state_e;

  localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             clear_q, load_q, upcnt_q, run_q;

  logic [31:0]      w_period;
  logic [CNT_W-1:0] w_reload;

  // Reload value P-1 with P = max(BASE_PERIOD >> speed, 1).
  assign w_period = 32'(BASE_PERIOD) >> SC_BACKGSCROLL_speed_In;
  assign w_reload = (w_period == 32'd0) ? '0 : CNT_W'(w_period - 32'd1);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    row_d   = row_q;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (!SC_BACKGSCROLL_startButton_InLow) state_d = S_INIT;
      end
      S_INIT: begin
        row_d   = '0;
        presc_d = w_reload;
        state_d = S_WAIT_REL;
      end
      // Holding the button must not retrigger INIT; wait for release.
      S_WAIT_REL: begin
        if (SC_BACKGSCROLL_startButton_InLow) state_d = S_RUN;
      end
      S_RUN: begin
        if (!SC_BACKGSCROLL_startButton_InLow)  state_d = S_INIT;
        else if (!SC_BACKGSCROLL_pause_InLow)   state_d = S_PAUSE;
        else if (presc_q == '0)                 state_d = S_SHIFT;
        else                                    presc_d = presc_q - 1'b1;
      end
      S_SHIFT: begin
        row_d   = (row_q == c_LAST_ROW) ? '0 : row_q + 1'b1;
        state_d = S_COUNT;
      end
      // Speed is re-sampled only here and in INIT, so a running period
      // finishes at its original rate.
      S_COUNT: begin
        presc_d = w_reload;
        state_d = S_RUN;
      end
      S_PAUSE: begin
        if (!SC_BACKGSCROLL_startButton_InLow) state_d = S_INIT;
        else if (SC_BACKGSCROLL_pause_InLow)   state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state
  // register and remain glitch-free.
  always_ff @(posedge SC_BACKGSCROLL_CLOCK_50) begin
    if (!SC_BACKGSCROLL_RESET_InLow) begin
      state_q <= S_RESET;
      presc_q <= '0;
      row_q   <= '0;
      clear_q <= 1'b1;
      load_q  <= 1'b1;
      upcnt_q <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      row_q   <= row_d;
      clear_q <= (state_d != S_INIT);
      load_q  <= (state_d != S_SHIFT);
      upcnt_q <= (state_d != S_COUNT);
      run_q   <= (state_d == S_RUN) || (state_d == S_SHIFT) ||
                 (state_d == S_COUNT) || (state_d == S_PAUSE);
    end
  end

`ifdef SC_BACKGSCROLL_WRAP_IRQ_EN
  logic wrap_q;

  // SHIFT always hands over to COUNT, so a wrap seen in SHIFT lands the
  // strobe exactly on the COUNT cycle.
  always_ff @(posedge SC_BACKGSCROLL_CLOCK_50) begin
    if (!SC_BACKGSCROLL_RESET_InLow) begin
      wrap_q <= 1'b1;
    end else begin
      wrap_q <= ~((state_q == S_SHIFT) && (row_q == c_LAST_ROW));
    end
  end

  assign SC_BACKGSCROLL_wrap_OutLow = wrap_q;
`else
  assign SC_BACKGSCROLL_wrap_OutLow = 1'b1;
`endif

  assign SC_BACKGSCROLL_clear_OutLow   = clear_q;
  assign SC_BACKGSCROLL_load_OutLow    = load_q;
  assign SC_BACKGSCROLL_upcount_OutLow = upcnt_q;
  assign SC_BACKGSCROLL_rowIndex_Out   = row_q;
  assign SC_BACKGSCROLL_running_Out    = run_q;

endmodule
`default_nettype wire
